// File: rtl/hot_vec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hot_vec_pkg                                                          |
// | Shared types and helpers for the hot vector scanner.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hot_vec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int hv_clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; (1 << k) < n; k++) r = k + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | priority_encoder_param                                               |
// | Two-level lowest-set-bit encoder: GROUP-wide sub-encoders feeding a  |
// | group-valid encoder.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module priority_encoder_param
    import hot_vec_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int GROUP = 4,
    parameter int IDX_W = hv_clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    localparam int NGRP = WIDTH / GROUP;
    localparam int GW   = (GROUP > 1) ? hv_clog2(GROUP) : 1;

    logic [NGRP-1:0] w_grp_any;
    logic [GW-1:0]   w_grp_idx [NGRP];

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        logic [GW-1:0] w_loc;

        always_comb begin
            w_loc = '0;
            for (int b = GROUP - 1; b >= 0; b--) begin
                if (vec[g*GROUP + b]) w_loc = GW'(b);
            end
        end

        assign w_grp_any[g] = |vec[g*GROUP +: GROUP];
        assign w_grp_idx[g] = w_loc;
    end

    // Scanning downward leaves the lowest populated group as the winner.
    always_comb begin
        any = |w_grp_any;
        idx = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (w_grp_any[g]) idx = IDX_W'(g * GROUP) + IDX_W'(w_grp_idx[g]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/hot_vector_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hot_vector_scanner                                                   |
// | Loads a hot vector and drains one set-bit index per handshake, in    |
// | fixed LSB-first or round-robin order.                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hot_vector_scanner
    import hot_vec_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int GROUP = 4,
    parameter int IDX_W = hv_clog2(WIDTH),
    parameter int CNT_W = hv_clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] hot_vector_i,
    input  logic             mode_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic             flush_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] remaining_o,
    output logic             done_o
);

    localparam logic [IDX_W-1:0] c_LAST_RST = IDX_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_pending;
    logic             r_mode;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_remaining;
    logic             r_load_ready;
    logic             r_done;

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] w_pop;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_all_idx;
    logic [IDX_W-1:0] w_sel;
    logic             w_hi_any;
    logic             w_all_any;

    always_comb begin
        w_mask = '0;
        w_pop  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_mask[i] = (i > int'(r_last));
            w_pop     = w_pop + CNT_W'(hot_vector_i[i]);
        end
    end

    priority_encoder_param #(.WIDTH(WIDTH), .GROUP(GROUP), .IDX_W(IDX_W)) u_enc_hi (
        .vec (r_pending & w_mask),
        .idx (w_hi_idx),
        .any (w_hi_any)
    );

    priority_encoder_param #(.WIDTH(WIDTH), .GROUP(GROUP), .IDX_W(IDX_W)) u_enc_all (
        .vec (r_pending),
        .idx (w_all_idx),
        .any (w_all_any)
    );

    // An empty upper search means the round-robin pointer wraps to the bottom.
    assign w_sel  = (r_mode == MODE_RR && w_hi_any) ? w_hi_idx : w_all_idx;
    assign w_next = r_pending & ~(WIDTH'(1) << w_sel);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= IDLE;
            r_pending    <= '0;
            r_mode       <= MODE_FIXED;
            r_last       <= c_LAST_RST;
            r_remaining  <= '0;
            r_load_ready <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!flush_i && load_valid_i) begin
                        r_pending    <= hot_vector_i;
                        r_mode       <= mode_i;
                        r_remaining  <= w_pop;
                        r_load_ready <= 1'b0;
                        if (hot_vector_i != '0) begin
                            r_state <= SCAN;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (ready_i) r_last <= w_sel;
                    if (flush_i) begin
                        r_state      <= IDLE;
                        r_pending    <= '0;
                        r_remaining  <= '0;
                        r_load_ready <= 1'b1;
                    end else if (ready_i) begin
                        r_pending   <= w_next;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_next == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_pending    <= '0;
                    r_remaining  <= '0;
                    r_load_ready <= 1'b1;
                end
                default: begin
                    r_state      <= IDLE;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign load_ready_o = r_load_ready;
    assign valid_o      = (r_state == SCAN) && w_all_any;
    assign idx_o        = w_sel;
    assign remaining_o  = r_remaining;
    assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hot_vector_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hot_vector_scanner                                                |
// | Directed, table-driven bench for hot_vector_scanner (WIDTH=20).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hot_vector_scanner;

    localparam int WIDTH = 20;
    localparam int GROUP = 4;
    localparam int IDX_W = 5;
    localparam int CNT_W = 5;
    localparam int NROWS = 10;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic [WIDTH-1:0] hot_vector_i = '0;
    logic             mode_i = 1'b0;
    logic             load_valid_i = 1'b0;
    logic             load_ready_o;
    logic             flush_i = 1'b0;
    logic [IDX_W-1:0] idx_o;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [CNT_W-1:0] remaining_o;
    logic             done_o;

    always #5 clk_i = ~clk_i;

    hot_vector_scanner #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .hot_vector_i (hot_vector_i),
        .mode_i       (mode_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .flush_i      (flush_i),
        .idx_o        (idx_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .remaining_o  (remaining_o),
        .done_o       (done_o)
    );

    typedef logic [7:0][IDX_W-1:0] seq_t;

    typedef struct {
        logic [WIDTH-1:0] vec;
        logic             mode;
        int               n;
        seq_t             seq;
    } row_t;

    row_t rows [NROWS];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic seq_t mk(input int a, input int b, input int c, input int d);
        seq_t r;
        r    = '0;
        r[0] = IDX_W'(a);
        r[1] = IDX_W'(b);
        r[2] = IDX_W'(c);
        r[3] = IDX_W'(d);
        return r;
    endfunction

    task automatic set_row(input int i, input logic [WIDTH-1:0] v, input logic m,
                           input int n, input seq_t s);
        rows[i].vec  = v;
        rows[i].mode = m;
        rows[i].n    = n;
        rows[i].seq  = s;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " load_ready"}, 32'(load_ready_o), 1);
        check({tag, " valid"},      32'(valid_o), 0);
        check({tag, " idx"},        32'(idx_o), 0);
        check({tag, " remaining"},  32'(remaining_o), 0);
        check({tag, " done"},       32'(done_o), 0);
    endtask

    // Load one vector with ready held high and follow it to the done pulse.
    task automatic drain(input logic [WIDTH-1:0] v, input logic m, input int n,
                         input seq_t s, input string tag);
        check({tag, " load_ready"}, 32'(load_ready_o), 1);
        load_valid_i = 1'b1;
        hot_vector_i = v;
        mode_i       = m;
        ready_i      = 1'b1;
        @(negedge clk_i);
        load_valid_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s idx%0d", tag, k),   32'(idx_o), 32'(s[k]));
            check($sformatf("%s valid%0d", tag, k), 32'(valid_o), 1);
            check($sformatf("%s rem%0d", tag, k),   32'(remaining_o), 32'(n - k));
            @(negedge clk_i);
        end
        check({tag, " done"},       32'(done_o), 1);
        check({tag, " done valid"}, 32'(valid_o), 0);
        check({tag, " done rem"},   32'(remaining_o), 0);
        @(negedge clk_i);
        check({tag, " post done"},  32'(done_o), 0);
        check({tag, " post ready"}, 32'(load_ready_o), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        set_row(0, 20'h80021, 1'b0, 3, mk(0, 5, 19, 0));
        set_row(1, 20'h00020, 1'b0, 1, mk(5, 0, 0, 0));
        set_row(2, 20'h00061, 1'b1, 3, mk(6, 0, 5, 0));
        set_row(3, 20'h80001, 1'b1, 2, mk(19, 0, 0, 0));
        set_row(4, 20'h80000, 1'b1, 1, mk(19, 0, 0, 0));
        set_row(5, 20'h00001, 1'b1, 1, mk(0, 0, 0, 0));
        set_row(6, 20'h00000, 1'b0, 0, mk(0, 0, 0, 0));
        set_row(7, 20'h0A400, 1'b0, 3, mk(10, 13, 15, 0));
        set_row(8, 20'h0A401, 1'b1, 4, mk(0, 10, 13, 15));
        set_row(9, 20'h10010, 1'b0, 2, mk(4, 16, 0, 0));

        reset_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check_idle("reset");
        reset_i = 1'b0;
        @(negedge clk_i);

        for (int r = 0; r < NROWS; r++) begin
            drain(rows[r].vec, rows[r].mode, rows[r].n, rows[r].seq, $sformatf("row%0d", r));
        end

        // Backpressure: outputs hold while ready is low.
        load_valid_i = 1'b1;
        hot_vector_i = 20'h00300;
        mode_i       = 1'b0;
        ready_i      = 1'b0;
        @(negedge clk_i);
        load_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp hold idx%0d", c),   32'(idx_o), 8);
            check($sformatf("bp hold rem%0d", c),   32'(remaining_o), 2);
            check($sformatf("bp hold valid%0d", c), 32'(valid_o), 1);
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        check("bp idx8", 32'(idx_o), 8);
        @(negedge clk_i);
        check("bp idx9", 32'(idx_o), 9);
        check("bp rem1", 32'(remaining_o), 1);
        @(negedge clk_i);
        check("bp done", 32'(done_o), 1);
        @(negedge clk_i);
        check("bp ready", 32'(load_ready_o), 1);

        // Flush after two indices; the handshake in the flush cycle moves last_q to 2.
        load_valid_i = 1'b1;
        hot_vector_i = 20'hFFFFF;
        mode_i       = 1'b0;
        @(negedge clk_i);
        load_valid_i = 1'b0;
        check("abort idx0", 32'(idx_o), 0);
        check("abort rem0", 32'(remaining_o), 20);
        @(negedge clk_i);
        check("abort idx1", 32'(idx_o), 1);
        check("abort rem1", 32'(remaining_o), 19);
        @(negedge clk_i);
        check("abort idx2", 32'(idx_o), 2);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check_idle("flush");
        @(negedge clk_i);
        check("flush no done", 32'(done_o), 0);
        drain(20'h0000D, 1'b1, 3, mk(3, 0, 2, 0), "rr after flush");

        // Flush in IDLE beats a simultaneous load.
        flush_i      = 1'b1;
        load_valid_i = 1'b1;
        hot_vector_i = 20'h00001;
        @(negedge clk_i);
        flush_i      = 1'b0;
        load_valid_i = 1'b0;
        check_idle("idle flush");
        @(negedge clk_i);
        check_idle("idle flush +1");

        // Reset mid-drain, then confirm the RR pointer restarted at bit 0.
        load_valid_i = 1'b1;
        hot_vector_i = 20'h00006;
        mode_i       = 1'b0;
        @(negedge clk_i);
        load_valid_i = 1'b0;
        check("mid idx1", 32'(idx_o), 1);
        @(negedge clk_i);
        check("mid idx2", 32'(idx_o), 2);
        reset_i = 1'b1;
        ready_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        check_idle("mid reset");
        drain(20'h000C3, 1'b1, 4, mk(0, 1, 6, 7), "rr after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
